// File: rtl/mem_ctrl_resp_pkg.sv
// Shared types and helpers for the mem_ctrl_resp memory responder.
// The optional MEM_CTRL_RESP_RANGE_ERR_EN build adds an address range error flag.
package mem_ctrl_resp_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_WAIT    = 3'd1,
    RD_BURST   = 3'd2,
    WR_CAPTURE = 3'd3,
    WR_WAIT    = 3'd4
  } state_e;

  localparam int DEF_AWIDTH     = 16;
  localparam int DEF_DWIDTH     = 8;
  localparam int DEF_BLOCKSIZE  = 4;
  localparam int DEF_MEMAWIDTH  = 10;
  localparam int DEF_RD_LATENCY = 4;
  localparam int DEF_WR_LATENCY = 6;

  // Width of a counter that must be able to hold max_count itself.
  function automatic int cnt_width(input int max_count);
    if (max_count < 2) begin
      return 1;
    end else begin
      return $clog2(max_count + 1);
    end
  endfunction

endpackage

// File: rtl/mem_ctrl_resp_if.sv
// Command/handshake bundle between the cache (master) and mem_ctrl_resp (slave).
// err_mem only exists when MEM_CTRL_RESP_RANGE_ERR_EN is defined.
interface mem_ctrl_resp_if #(
  parameter int AWIDTH = 16
) ();
  logic [AWIDTH-1:0] addr_mem;
  logic              rd_mem;
  logic              wr_mem;
  logic              ready_mem;
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
  logic              err_mem;

  modport master (output addr_mem, output rd_mem, output wr_mem,
                  input ready_mem, input err_mem);
  modport slave  (input addr_mem, input rd_mem, input wr_mem,
                  output ready_mem, output err_mem);
`else
  modport master (output addr_mem, output rd_mem, output wr_mem,
                  input ready_mem);
  modport slave  (input addr_mem, input rd_mem, input wr_mem,
                  output ready_mem);
`endif
endinterface

// File: rtl/mem_ctrl_resp_array.sv
// Byte-wide backing store: combinational byte read, whole-block synchronous write.
// Contents are intentionally not reset.
module mem_ctrl_resp_array
  import mem_ctrl_resp_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int BLOCKSIZE = DEF_BLOCKSIZE,
  parameter int MEMAWIDTH = DEF_MEMAWIDTH
) (
  input  logic                          clock,
  input  logic [MEMAWIDTH-1:0]          rd_addr_i,
  output logic [DWIDTH-1:0]             rd_data_o,
  input  logic                          wr_en_i,
  input  logic [MEMAWIDTH-$clog2(BLOCKSIZE)-1:0] wr_blk_i,
  input  logic [BLOCKSIZE*DWIDTH-1:0]   wr_data_i
);
  localparam int DEPTH = 1 << MEMAWIDTH;
  localparam int IDX_W = $clog2(BLOCKSIZE);

  logic [DWIDTH-1:0] store_q [DEPTH];

  assign rd_data_o = store_q[rd_addr_i];

  // Commit every byte of the block buffer in a single edge.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      for (int i = 0; i < BLOCKSIZE; i++) begin
        store_q[{wr_blk_i, IDX_W'(i)}] <= wr_data_i[i*DWIDTH +: DWIDTH];
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_resp.sv
// Memory-side responder for the cache memory port: block reads/writes over a shared byte bus.
// Define MEM_CTRL_RESP_RANGE_ERR_EN to flag (and neutralise) addresses beyond the store.
module mem_ctrl_resp
  import mem_ctrl_resp_pkg::*;
#(
  parameter int AWIDTH     = DEF_AWIDTH,
  parameter int DWIDTH     = DEF_DWIDTH,
  parameter int BLOCKSIZE  = DEF_BLOCKSIZE,
  parameter int MEMAWIDTH  = DEF_MEMAWIDTH,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int WR_LATENCY = DEF_WR_LATENCY
) (
  input  logic              clock,
  input  logic              reset_n,
  mem_ctrl_resp_if.slave    mem,
  inout  wire [DWIDTH-1:0]  data_mem
);
  localparam int IDX_W  = $clog2(BLOCKSIZE);
  localparam int BLK_W  = MEMAWIDTH - IDX_W;
  localparam int BEAT_W = cnt_width(BLOCKSIZE);
  localparam int LAT_W  = cnt_width((RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY);

  state_e                    state_q;
  logic                      ready_q;
  logic                      drive_q;
  logic [DWIDTH-1:0]         rdata_q;
  logic [BLK_W-1:0]          blk_q;
  logic [BEAT_W-1:0]         beat_q;
  logic [LAT_W-1:0]          lat_q;
  logic [BLOCKSIZE*DWIDTH-1:0] wbuf_q;
  logic                      commit_q;
  logic                      oor_q;
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
  logic                      err_q;
`endif

  logic [IDX_W-1:0]          beat_idx_d;
  logic [MEMAWIDTH-1:0]      rd_idx_d;
  logic [DWIDTH-1:0]         rd_data_d;
  logic                      wr_en_d;
  logic                      range_err_d;
  logic                      addr_unused_d;

  assign beat_idx_d = beat_q[IDX_W-1:0];
  assign rd_idx_d   = {blk_q, beat_idx_d};
  // The store is written once, on the first WR_WAIT cycle; dropped if out of range.
  assign wr_en_d    = (state_q == WR_WAIT) && !commit_q && !oor_q;
  // Block offset bits are ignored, and high bits only matter to the range check.
  assign addr_unused_d = ^{mem.addr_mem[AWIDTH-1:MEMAWIDTH], mem.addr_mem[IDX_W-1:0]};

`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
  assign range_err_d = |mem.addr_mem[AWIDTH-1:MEMAWIDTH];
  assign mem.err_mem = err_q;
`else
  assign range_err_d = 1'b0;
`endif

  assign mem.ready_mem = ready_q;
  // Never contend with the cache while it is asserting a write.
  assign data_mem = (drive_q && !mem.wr_mem) ? rdata_q : {DWIDTH{1'bz}};

  mem_ctrl_resp_array #(
    .DWIDTH    (DWIDTH),
    .BLOCKSIZE (BLOCKSIZE),
    .MEMAWIDTH (MEMAWIDTH)
  ) u_array (
    .clock     (clock),
    .rd_addr_i (rd_idx_d),
    .rd_data_o (rd_data_d),
    .wr_en_i   (wr_en_d),
    .wr_blk_i  (blk_q),
    .wr_data_i (wbuf_q)
  );

  // Command FSM with beat/latency counters and registered bus outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      drive_q  <= 1'b0;
      rdata_q  <= '0;
      blk_q    <= '0;
      beat_q   <= '0;
      lat_q    <= '0;
      wbuf_q   <= '0;
      commit_q <= 1'b0;
      oor_q    <= 1'b0;
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          drive_q  <= 1'b0;
          beat_q   <= '0;
          commit_q <= 1'b0;
          if (ready_q && (mem.wr_mem || mem.rd_mem)) begin
            blk_q <= mem.addr_mem[MEMAWIDTH-1:IDX_W];
            oor_q <= range_err_d;
            lat_q <= LAT_W'(1);
            if (mem.wr_mem) begin
              state_q <= WR_CAPTURE;
              ready_q <= 1'b0;
            end else if (RD_LATENCY <= 1) begin
              state_q <= RD_BURST;
              ready_q <= 1'b1;
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
              err_q   <= range_err_d;
`endif
            end else begin
              state_q <= RD_WAIT;
              ready_q <= 1'b0;
            end
          end
        end
        RD_WAIT: begin
          if (lat_q >= LAT_W'(RD_LATENCY - 1)) begin
            state_q <= RD_BURST;
            ready_q <= 1'b1;
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
            err_q   <= oor_q;
`endif
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        RD_BURST: begin
          // First RD_BURST cycle is the ready-only preamble; beats follow.
          if (beat_q < BEAT_W'(BLOCKSIZE)) begin
            drive_q <= 1'b1;
            rdata_q <= oor_q ? '0 : rd_data_d;
            beat_q  <= beat_q + BEAT_W'(1);
          end else begin
            drive_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        WR_CAPTURE: begin
          lat_q <= lat_q + LAT_W'(1);
          if (lat_q >= LAT_W'(2)) begin
            wbuf_q[beat_idx_d*DWIDTH +: DWIDTH] <= data_mem;
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(BLOCKSIZE - 1)) begin
              state_q <= WR_WAIT;
            end
          end
        end
        WR_WAIT: begin
          commit_q <= 1'b1;
          if (lat_q >= LAT_W'(WR_LATENCY)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
`ifdef MEM_CTRL_RESP_RANGE_ERR_EN
            err_q   <= oor_q;
`endif
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
